// File: rtl/icache_axi_pkg.sv
// Shared types and constants for the icache refill read channel.
// Used by the memory-side responder and its skid FIFO.
package icache_axi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    localparam int         BEAT_BYTES     = 4;
    localparam int         LINE_BEATS     = 4;
    localparam logic [7:0] ARLEN_UNCACHED = 8'd0;
    localparam logic [7:0] ARLEN_LINE     = 8'd3;

    function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding {data, last} beats between the SRAM and the R channel.
// Push and pop in the same cycle are legal in any fill state, including full.
module rd_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/icache_rd_responder.sv
// Memory-side read responder for the icache refill port: accepts one burst,
// reads a 1-cycle-latency SRAM and streams beats with i_rlast.
//
//   state | meaning
//   IDLE  | waiting for an AR handshake (i_arready high once out of reset)
//   BURST | issuing SRAM reads and draining beats until the i_rlast handshake
module icache_rd_responder
    import icache_axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_AW  = 14,
    parameter int MAX_LEN = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int ISS_W = LEN_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    rd_state_e         state_q, state_d;
    logic              rst_done_q;
    logic [WA_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              issue_last;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W:0]   fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [2:0]        occupancy;
    logic              bypass;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^i_araddr[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            rst_done_q      <= 1'b0;
            addr_q          <= '0;
            rem_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rst_done_q      <= 1'b1;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            issued_q        <= issued_d;
            inflight_q      <= ram_en;
            inflight_last_q <= ram_en & issue_last;
        end
    end

    assign i_arready  = rst_done_q && (state_q == IDLE);
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue_last = (issued_q == {1'b0, rem_q});
    assign ram_addr   = addr_q[RAM_AW-1:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        issued_d = issued_q;
        ram_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_arvalid && i_arready) begin
                    addr_d   = i_araddr[ADDR_W-1:2];
                    rem_d    = LEN_W'(clamp_len(i_arlen, 8'(MAX_LEN)));
                    issued_d = '0;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if ((issued_q <= {1'b0, rem_q}) && (occupancy < 3'd2)) begin
                    ram_en   = 1'b1;
                    addr_d   = addr_q + WA_W'(1);
                    issued_d = issued_q + ISS_W'(1);
                end
                if (i_rvalid && i_rready && i_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM data returning into an empty FIFO is presented directly, so the
    // first beat appears the cycle after ram_en; it is only stored if stalled.
    assign bypass    = fifo_empty && inflight_q;
    assign i_rvalid  = !fifo_empty || inflight_q;
    assign fifo_pop  = !fifo_empty && i_rready;
    assign fifo_push = inflight_q && !(fifo_empty && i_rready);
    assign {i_rlast, i_rdata} = bypass ? {inflight_last_q, ram_rdata} : fifo_head;

    rd_skid_fifo #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (fifo_push),
        .push_data_i ({inflight_last_q, ram_rdata}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_icache_rd_responder.sv
// Scoreboard bench for icache_rd_responder: expected beats are queued at each
// AR handshake from a flat memory image; a monitor pops and compares beats.
module tb_icache_rd_responder;
    import icache_axi_pkg::*;

    localparam int RAM_AW = 14;
    localparam int DEPTH  = 1 << RAM_AW;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_arvalid = 1'b0;
    logic        i_arready;
    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic        i_rvalid;
    logic        i_rready = 1'b0;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        ram_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:DEPTH-1];
    logic [32:0] exp_q [$];
    int          bcyc [$];
    int          alog [$];
    int          cyc = 0;
    int          ren_cnt = 0;
    int          bcnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rr_rand = 0;

    icache_rd_responder dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_arvalid (i_arvalid),
        .i_arready (i_arready),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_rvalid  (i_rvalid),
        .i_rready  (i_rready),
        .i_rdata   (i_rdata),
        .i_rlast   (i_rlast),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rr_rand) i_rready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input bit hold, output int t);
        int n;
        int w;
        i_araddr  = a;
        i_arlen   = len;
        i_arvalid = 1'b1;
        t = -1;
        for (int k = 0; k < 3000 && !i_arready; k++) step();
        if (!i_arready) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout: arready got 0 expected 1 (cycle %0d)", cyc);
            i_arvalid = 1'b0;
        end else begin
            t = cyc;
            n = (int'(len) > 15) ? 15 : int'(len);
            w = int'(a[RAM_AW+1:2]);
            for (int k = 0; k <= n; k++) exp_q.push_back({(k == n), mem[(w + k) % DEPTH]});
            step();
            if (!hold) i_arvalid = 1'b0;
        end
    endtask

    task automatic wait_done(input int max);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || i_rvalid) && k < max) begin
            step();
            k++;
        end
        chk("drain_done", 64'(exp_q.size() == 0 && !i_rvalid), 64'd1);
    endtask

    initial begin
        int t, t2, r0, b0, n;
        logic [7:0] len;
        bit hold;
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};

        fork
            begin : monitor
                bit pv;
                logic [31:0] pd;
                logic pl;
                logic [32:0] e;
                pv = 0;
                pd = '0;
                pl = 0;
                forever begin
                    @(negedge clk);
                    if (!rstn) begin
                        pv = 0;
                        ren_cnt = 0;
                        bcnt = 0;
                        continue;
                    end
                    if (pv) begin
                        chk("hold_valid", 64'(i_rvalid), 64'd1);
                        chk("hold_data", 64'(i_rdata), 64'(pd));
                        chk("hold_last", 64'(i_rlast), 64'(pl));
                    end
                    if (ram_en) begin
                        ren_cnt++;
                        alog.push_back(int'(ram_addr));
                    end
                    if (i_rvalid && i_rready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", i_rdata, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", 64'(i_rdata), 64'(e[31:0]));
                            chk("beat_last", 64'(i_rlast), 64'(e[32]));
                        end
                        bcnt++;
                        bcyc.push_back(cyc);
                    end
                    chk("outstanding_le2", 64'((ren_cnt - bcnt) <= 2), 64'd1);
                    pv = i_rvalid && !i_rready;
                    pd = i_rdata;
                    pl = i_rlast;
                end
            end
        join_none

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[256 + i] = 32'hA0 + 32'(i);

        // reset values
        #22;
        chk("rst_arready", 64'(i_arready), 64'd0);
        chk("rst_rvalid", 64'(i_rvalid), 64'd0);
        chk("rst_rlast", 64'(i_rlast), 64'd0);
        chk("rst_rdata", 64'(i_rdata), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("arready_before_first_edge", 64'(i_arready), 64'd0);
        step();
        chk("arready_after_first_edge", 64'(i_arready), 64'd1);

        // line refill with timing
        i_rready = 1'b1;
        bcyc.delete();
        do_ar(32'h400, ARLEN_LINE, 0, t);
        wait_done(100);
        chk("line_beats", 64'(bcyc.size()), 64'd4);
        if (bcyc.size() == 4)
            for (int k = 0; k < 4; k++) chk("line_beat_cycle", 64'(bcyc[k]), 64'(t + 2 + k));
        chk("line_rearm_cycle", 64'(cyc), 64'(t + 6));
        chk("line_rearm_arready", 64'(i_arready), 64'd1);

        // uncached word
        r0 = ren_cnt;
        b0 = bcnt;
        do_ar(32'h40C, ARLEN_UNCACHED, 0, t);
        wait_done(100);
        chk("uncached_ram_en_count", 64'(ren_cnt - r0), 64'd1);
        chk("uncached_beats", 64'(bcnt - b0), 64'd1);

        // backpressure
        b0 = bcnt;
        do_ar(32'h2000, ARLEN_LINE, 0, t);
        for (int k = 0; k < 7; k++) begin
            i_rready = pat[k];
            step();
        end
        i_rready = 1'b1;
        wait_done(100);
        chk("bp_beats", 64'(bcnt - b0), 64'd4);

        // wrap and clamp
        alog.delete();
        b0 = bcnt;
        do_ar(32'h0000_FFFC, 8'd20, 0, t);
        wait_done(300);
        chk("clamp_beats", 64'(bcnt - b0), 64'd16);
        chk("clamp_issues", 64'(alog.size()), 64'd16);
        if (alog.size() >= 2) begin
            chk("wrap_first_addr", 64'(alog[0]), 64'(DEPTH - 1));
            chk("wrap_second_addr", 64'(alog[1]), 64'd0);
        end

        // reset mid-burst
        b0 = bcnt;
        do_ar(32'h400, ARLEN_LINE, 0, t);
        for (int k = 0; k < 20 && (bcnt - b0) < 1; k++) step();
        chk("midrst_one_beat", 64'(bcnt - b0), 64'd1);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_rvalid", 64'(i_rvalid), 64'd0);
        chk("midrst_ram_en", 64'(ram_en), 64'd0);
        chk("midrst_arready", 64'(i_arready), 64'd0);
        chk("midrst_rlast", 64'(i_rlast), 64'd0);
        repeat (2) step();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midrst_arready_release", 64'(i_arready), 64'd0);
        step();
        chk("midrst_arready_edge", 64'(i_arready), 64'd1);
        bcyc.delete();
        do_ar(32'h404, ARLEN_LINE, 0, t);
        wait_done(100);
        chk("midrst_fresh_beats", 64'(bcyc.size()), 64'd4);
        if (bcyc.size() == 4) chk("midrst_fresh_last_cycle", 64'(bcyc[3]), 64'(t + 5));

        // back-to-back with AR held
        bcyc.delete();
        do_ar(32'h1230, ARLEN_LINE, 1, t);
        do_ar(32'h5670, ARLEN_LINE, 0, t2);
        chk("b2b_accept_cycle", 64'(t2), 64'(t + 6));
        if (bcyc.size() >= 4) chk("b2b_after_last", 64'(t2), 64'(bcyc[3] + 1));
        wait_done(100);

        // randomized bursts and backpressure
        rr_rand = 1;
        for (int it = 0; it < 40; it++) begin
            n = int'($urandom_range(0, 3));
            case (n)
                0:       len = ARLEN_UNCACHED;
                1:       len = ARLEN_LINE;
                2:       len = 8'($urandom_range(0, 20));
                default: len = 8'($urandom_range(0, 255));
            endcase
            hold = ($urandom_range(0, 3) == 0);
            do_ar($urandom, len, hold, t);
            if (!hold) begin
                if ($urandom_range(0, 1) == 1) wait_done(3000);
                else repeat ($urandom_range(0, 3)) step();
            end
        end
        i_arvalid = 1'b0;
        rr_rand = 0;
        i_rready = 1'b1;
        wait_done(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
